// File: rtl/task_packetizer_pkg.sv
// Shared types and default service codes for the task packetizer.
// Frames the parser word stream into NEW_APP and TASK_ALLOCATION NoC packets.
package task_packetizer_pkg;

  typedef enum logic [4:0] {
    A_G, A_T,
    D_HDR, D_SIZE, D_SRV, D_G, D_T, D_MAP, D_TTT, D_GRAPH,
    K_TEXT, K_DATA, K_HDR, K_SIZE, K_SRV, K_TEXT_O, K_DATA_O, K_PASS,
    DONE
  } fsm_t;

  localparam logic [31:0] SVC_NEW_APP_DEF    = 32'h0000_0040;
  localparam logic [31:0] SVC_TASK_ALLOC_DEF = 32'h0000_0041;

endpackage

// File: rtl/task_map_table.sv
// Task-to-PE mapping table: one write port, one asynchronous read port.
// Entries reset to 16'hFFFF, which marks a task as dynamically mapped.
module task_map_table #(
  parameter int MAX_TASKS = 32,
  parameter int IDX_W     = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [15:0]      wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [15:0]      rd_data
);

  logic [15:0] mem_q [MAX_TASKS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MAX_TASKS; i++) mem_q[i] <= 16'hFFFF;
    end else if (we && (int'(wr_idx) < MAX_TASKS)) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign rd_data = (int'(rd_idx) < MAX_TASKS) ? mem_q[rd_idx] : 16'hFFFF;

endmodule

// File: rtl/task_packetizer.sv
// Consumes the task parser stream and emits a NEW_APP packet per application
// and a TASK_ALLOCATION packet per task, routed through the mapping table.
module task_packetizer
  import task_packetizer_pkg::*;
#(
  parameter int          FLIT_SIZE      = 32,
  parameter int          MAX_TASKS      = 32,
  parameter logic [31:0] SVC_NEW_APP    = SVC_NEW_APP_DEF,
  parameter logic [31:0] SVC_TASK_ALLOC = SVC_TASK_ALLOC_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 tx_i,
  output logic                 credit_o,
  input  logic [FLIT_SIZE-1:0] data_i,
  input  logic                 eoa_i,
  input  logic [15:0]          mapper_address_i,
  output logic                 tx_o,
  input  logic                 credit_i,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic                 eoa_o,
  output logic                 error_o
);

  localparam int          IDX_W = (MAX_TASKS > 1) ? $clog2(MAX_TASKS) : 1;
  localparam logic [31:0] MAX_T = 32'(MAX_TASKS);

  function automatic logic [31:0] desc_size(input logic [31:0] g, input logic [31:0] t);
    return 32'd4 + (t << 1) + g;
  endfunction

  function automatic logic [31:0] bin_words(input logic [31:0] text, input logic [31:0] dsec);
    return (text + dsec) >> 2;
  endfunction

  fsm_t        state_q, state_d;
  logic        run_q, err_q, err_d;
  logic [31:0] k_q, k_d, cnt_q, cnt_d;
  logic [31:0] g_q, g_d, t_q, t_d, text_q, text_d, dsec_q, dsec_d;
  logic        tbl_we;
  logic [15:0] tbl_rd;
  logic [15:0] target;
  logic [31:0] word_in;

  assign word_in = data_i[31:0];
  assign error_o = err_q;

  task_map_table #(
    .MAX_TASKS (MAX_TASKS),
    .IDX_W     (IDX_W)
  ) u_table (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we      (tbl_we),
    .wr_idx  (k_q[IDX_W-1:0]),
    .wr_data (data_i[15:0]),
    .rd_idx  (k_q[IDX_W-1:0]),
    .rd_data (tbl_rd)
  );

  // Tasks beyond the table, or left unmapped, are handed to the mapper.
  assign target = ((tbl_rd == 16'hFFFF) || (k_q >= MAX_T)) ? mapper_address_i : tbl_rd;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= A_G;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
      k_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      err_q   <= err_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    g_q    <= g_d;
    t_q    <= t_d;
    text_q <= text_d;
    dsec_q <= dsec_d;
  end

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    g_d      = g_q;
    t_d      = t_q;
    text_d   = text_q;
    dsec_d   = dsec_q;
    tx_o     = 1'b0;
    credit_o = 1'b0;
    data_o   = '0;
    eoa_o    = 1'b0;
    tbl_we   = 1'b0;

    unique case (state_q)
      A_G: begin
        credit_o = 1'b1;
        if (tx_i) begin
          g_d     = word_in;
          state_d = A_T;
        end else if (eoa_i) begin
          state_d = DONE;
        end
      end
      A_T: begin
        credit_o = 1'b1;
        if (tx_i) begin
          t_d = word_in;
          if (word_in > MAX_T) err_d = 1'b1;
          state_d = D_HDR;
        end
      end
      D_HDR: begin
        tx_o   = 1'b1;
        data_o = FLIT_SIZE'(mapper_address_i);
        if (credit_i) state_d = D_SIZE;
      end
      D_SIZE: begin
        tx_o   = 1'b1;
        data_o = FLIT_SIZE'(desc_size(g_q, t_q));
        if (credit_i) state_d = D_SRV;
      end
      D_SRV: begin
        tx_o   = 1'b1;
        data_o = FLIT_SIZE'(SVC_NEW_APP);
        if (credit_i) state_d = D_G;
      end
      D_G: begin
        tx_o   = 1'b1;
        data_o = FLIT_SIZE'(g_q);
        if (credit_i) state_d = D_T;
      end
      D_T: begin
        tx_o   = 1'b1;
        data_o = FLIT_SIZE'(t_q);
        if (credit_i) begin
          k_d = '0;
          if (t_q != 0) begin
            cnt_d   = t_q;
            state_d = D_MAP;
          end else if (g_q != 0) begin
            cnt_d   = g_q;
            state_d = D_GRAPH;
          end else begin
            state_d = A_G;
          end
        end
      end
      D_MAP: begin
        tx_o     = tx_i;
        credit_o = credit_i;
        data_o   = data_i;
        if (tx_i && credit_i) begin
          tbl_we  = (k_q < MAX_T);
          state_d = D_TTT;
        end
      end
      D_TTT: begin
        tx_o     = tx_i;
        credit_o = credit_i;
        data_o   = data_i;
        if (tx_i && credit_i) begin
          k_d   = k_q + 1;
          cnt_d = cnt_q - 1;
          if (cnt_q == 1) begin
            k_d = '0;
            if (g_q != 0) begin
              cnt_d   = g_q;
              state_d = D_GRAPH;
            end else begin
              state_d = K_TEXT;
            end
          end else begin
            state_d = D_MAP;
          end
        end
      end
      D_GRAPH: begin
        tx_o     = tx_i;
        credit_o = credit_i;
        data_o   = data_i;
        if (tx_i && credit_i) begin
          cnt_d = cnt_q - 1;
          if (cnt_q == 1) begin
            k_d     = '0;
            state_d = (t_q == 0) ? A_G : K_TEXT;
          end
        end
      end
      K_TEXT: begin
        credit_o = 1'b1;
        if (tx_i) begin
          text_d  = word_in;
          state_d = K_DATA;
        end
      end
      K_DATA: begin
        credit_o = 1'b1;
        if (tx_i) begin
          dsec_d  = word_in;
          state_d = K_HDR;
        end
      end
      K_HDR: begin
        tx_o   = 1'b1;
        data_o = FLIT_SIZE'(target);
        if (credit_i) state_d = K_SIZE;
      end
      K_SIZE: begin
        tx_o   = 1'b1;
        data_o = FLIT_SIZE'(32'd6 + bin_words(text_q, dsec_q));
        if (credit_i) state_d = K_SRV;
      end
      K_SRV: begin
        tx_o   = 1'b1;
        data_o = FLIT_SIZE'(SVC_TASK_ALLOC);
        if (credit_i) state_d = K_TEXT_O;
      end
      K_TEXT_O: begin
        tx_o   = 1'b1;
        data_o = FLIT_SIZE'(text_q);
        if (credit_i) state_d = K_DATA_O;
      end
      K_DATA_O: begin
        tx_o   = 1'b1;
        data_o = FLIT_SIZE'(dsec_q);
        if (credit_i) begin
          cnt_d   = 32'd2 + bin_words(text_q, dsec_q);
          state_d = K_PASS;
        end
      end
      K_PASS: begin
        tx_o     = tx_i;
        credit_o = credit_i;
        data_o   = data_i;
        if (tx_i && credit_i) begin
          cnt_d = cnt_q - 1;
          if (cnt_q == 1) begin
            k_d     = k_q + 1;
            state_d = ((k_q + 1) == t_q) ? A_G : K_TEXT;
          end
        end
      end
      DONE: begin
        eoa_o = 1'b1;
      end
      default: state_d = A_G;
    endcase

    // Hold everything quiet for the first cycle out of reset.
    if (!run_q) begin
      tx_o     = 1'b0;
      credit_o = 1'b0;
      data_o   = '0;
      eoa_o    = 1'b0;
      tbl_we   = 1'b0;
      state_d  = state_q;
      err_d    = err_q;
    end
  end

endmodule

// File: tb/tb_task_packetizer.sv
// Directed bench for task_packetizer: descriptor and task framing, routing,
// back-pressure, table overflow, mid-packet reset and end-of-applications.
module tb_task_packetizer;

  logic        clk, rst_ni;
  logic        tx_i, credit_o, eoa_i;
  logic [31:0] data_i, data_o;
  logic [15:0] mapper_address_i;
  logic        tx_o, credit_i, eoa_o, error_o;

  int compared   = 0;
  int mismatched = 0;
  bit toggle     = 0;

  logic [31:0] in_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] out_q[$];

  task_packetizer #(
    .FLIT_SIZE (32),
    .MAX_TASKS (4)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .tx_i             (tx_i),
    .credit_o         (credit_o),
    .data_i           (data_i),
    .eoa_i            (eoa_i),
    .mapper_address_i (mapper_address_i),
    .tx_o             (tx_o),
    .credit_i         (credit_i),
    .data_o           (data_o),
    .eoa_o            (eoa_o),
    .error_o          (error_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every flit accepted by the NoC, sampled just before the rising edge.
  always begin
    @(negedge clk);
    #4;
    if (tx_o && credit_i) out_q.push_back(data_o);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    credit_i = toggle ? ~credit_i : 1'b1;
  endtask

  task automatic idle(input int n);
    tx_i = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send(input logic [31:0] w);
    logic ok;
    int   n;
    tx_i = 1'b1;
    data_i = w;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 200) begin
      #4;
      ok = credit_o;
      tick();
      n++;
    end
    tx_i = 1'b0;
    if (!ok) check("credit_wait", {31'b0, ok}, 32'd1);
  endtask

  task automatic send_all(input bit gapped);
    for (int i = 0; i < in_q.size(); i++) begin
      if (gapped && (i % 3 == 1)) idle(1);
      send(in_q[i]);
    end
    in_q.delete();
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_len"}, 32'(out_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s[%0d]", tag, i), (i < out_q.size()) ? out_q[i] : 32'hxxxx_xxxx, exp_q[i]);
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic load_app1();
    in_q = '{32'd2, 32'd1, 32'h0102, 32'hFFFF_FFFF, 32'hA0, 32'hA1,
             32'h10, 32'h8, 32'hB0, 32'hE0,
             32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'hC5};
    exp_q = '{32'h0, 32'd8, 32'h40, 32'd2, 32'd1, 32'h0102, 32'hFFFF_FFFF, 32'hA0, 32'hA1,
              32'h0102, 32'd12, 32'h41, 32'h10, 32'h8, 32'hB0, 32'hE0,
              32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'hC5};
  endtask

  initial begin
    rst_ni = 1'b0;
    tx_i = 1'b0;
    data_i = '0;
    eoa_i = 1'b0;
    mapper_address_i = 16'h0000;
    credit_i = 1'b1;

    // Reset state
    idle(2);
    #4;
    check("rst_tx", {31'b0, tx_o}, 32'd0);
    check("rst_credit", {31'b0, credit_o}, 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_eoa", {31'b0, eoa_o}, 32'd0);
    check("rst_err", {31'b0, error_o}, 32'd0);
    tick();
    rst_ni = 1'b1;
    idle(3);
    #4;
    check("idle_credit", {31'b0, credit_o}, 32'd1);
    check("idle_tx", {31'b0, tx_o}, 32'd0);
    tick();

    // Static mapping, steady credit
    load_app1();
    send_all(1'b0);
    idle(40);
    compare_stream("app1");
    #4;
    check("app1_ag_credit", {31'b0, credit_o}, 32'd1);
    check("app1_err", {31'b0, error_o}, 32'd0);
    tick();

    // Same stream with toggling NoC credit and gapped input
    toggle = 1'b1;
    load_app1();
    send_all(1'b1);
    idle(100);
    toggle = 1'b0;
    tick();
    compare_stream("app1_bp");

    // Dynamic mapping, G=0, B=1
    mapper_address_i = 16'h0203;
    in_q = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h77, 32'h0, 32'h4, 32'hB1, 32'hE1, 32'hD0};
    exp_q = '{32'h0203, 32'd6, 32'h40, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'h77,
              32'h0203, 32'd7, 32'h41, 32'h0, 32'h4, 32'hB1, 32'hE1, 32'hD0};
    send_all(1'b0);
    idle(40);
    compare_stream("dyn");
    #4;
    check("dyn_err", {31'b0, error_o}, 32'd0);
    tick();

    // Table overflow: T = MAX_TASKS+1 = 5
    send(32'd0);
    send(32'd5);
    #4;
    check("ovf_err_set", {31'b0, error_o}, 32'd1);
    tick();
    exp_q = '{32'h0203, 32'd14, 32'h40, 32'd0, 32'd5};
    for (int i = 0; i < 5; i++) begin
      in_q.push_back(32'h11 + 32'(i));
      in_q.push_back(32'h70 + 32'(i));
      exp_q.push_back(32'h11 + 32'(i));
      exp_q.push_back(32'h70 + 32'(i));
    end
    for (int k = 0; k < 5; k++) begin
      in_q.push_back(32'h0);
      in_q.push_back(32'h0);
      in_q.push_back(32'hB0 + 32'(k));
      in_q.push_back(32'hE0 + 32'(k));
      exp_q.push_back((k < 4) ? 32'h11 + 32'(k) : 32'h0203);
      exp_q.push_back(32'd6);
      exp_q.push_back(32'h41);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'hB0 + 32'(k));
      exp_q.push_back(32'hE0 + 32'(k));
    end
    send_all(1'b0);
    idle(60);
    compare_stream("ovf");
    #4;
    check("ovf_err_sticky", {31'b0, error_o}, 32'd1);
    check("ovf_ag_credit", {31'b0, credit_o}, 32'd1);
    tick();

    // Reset while in K_PASS
    in_q = '{32'd0, 32'd1, 32'h0005, 32'h99, 32'h0, 32'h8, 32'hB5};
    exp_q = '{32'h0203, 32'd6, 32'h40, 32'd0, 32'd1, 32'h0005, 32'h99,
              32'h0005, 32'd8, 32'h41, 32'h0, 32'h8, 32'hB5};
    send_all(1'b0);
    compare_stream("pre_rst");
    tx_i = 1'b1;
    data_i = 32'hE5;
    #2;
    check("kpass_tx", {31'b0, tx_o}, 32'd1);
    check("kpass_data", data_o, 32'hE5);
    rst_ni = 1'b0;
    #1;
    check("midrst_tx", {31'b0, tx_o}, 32'd0);
    check("midrst_credit", {31'b0, credit_o}, 32'd0);
    check("midrst_data", data_o, 32'd0);
    check("midrst_err", {31'b0, error_o}, 32'd0);
    tx_i = 1'b0;
    idle(2);
    rst_ni = 1'b1;
    mapper_address_i = 16'h0000;
    idle(3);
    out_q.delete();
    load_app1();
    send_all(1'b0);
    idle(40);
    compare_stream("post_rst");

    // End of applications
    eoa_i = 1'b1;
    #4;
    check("eoa_same_cycle", {31'b0, eoa_o}, 32'd0);
    tick();
    #4;
    check("eoa_o", {31'b0, eoa_o}, 32'd1);
    check("eoa_credit", {31'b0, credit_o}, 32'd0);
    check("eoa_tx", {31'b0, tx_o}, 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
